dp_issue_ctrl: RTL and testbench
================================

// Module: dp_issue_ctrl
// PURPOSE
//  Issue/control FSM for ARM-style data-processing instructions; drives the ALU from the command side.
//  Accepts one 32-bit instruction per handshake and evaluates its condition field against current NZCV.
//  Sequences operand read, ALU_OP drive, the S flag-latch pulse and register write-back.
//  Sits between the instruction register and the ALU/register file; consumes the ALU's NZCV output.
// PARAMETERS
//  NV_EXECUTES  0  1: cond 4'hF executes as AL; 0: cond 4'hF never executes
// PORTS
//  clk        in   1   single clock; all state changes on posedge
//  rst_n      in   1   reset, synchronous and active-low
//  ir_valid   in   1   instruction available on ir
//  ir         in   32  instruction word
//  ir_ready   out  1   high in IDLE only; transfer = ir_valid & ir_ready
//  NZCV       in   4   ALU flags; bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V
//  ALU_OP     out  4   ALU operation select
//  S          out  1   flag-latch strobe to ALU (rising edge latches NZCV)
//  alu_c      out  1   carry-in to ALU, C captured at DECODE
//  rn_addr    out  4   operand A register address (ir[19:16])
//  rm_addr    out  4   operand B register address (ir[3:0])
//  rs_addr    out  4   shift-amount register address (ir[11:8])
//  rs_rd      out  1   one-cycle read strobe for Rs
//  imm_sel    out  1   1: operand B = rotated imm8 (ir[25])
//  shift_ctl  out  12  ir[11:0], held EXEC..WB for the shifter
//  rd_addr    out  4   destination address (ir[15:12])
//  reg_we     out  1   one-cycle register write enable
//  done       out  1   one-cycle completion pulse
//  err        out  1   one-cycle pulse with done for an illegal encoding
// BEHAVIOUR
//  Reset: state IDLE; ir_ready = 1; all other outputs = 0. Reset mid-operation aborts at that edge with no WB and no S.
//  States: IDLE -> DECODE -> [RD_RS] -> EXEC -> FLAG -> WB -> DONE -> IDLE.
//  IDLE: on transfer, latch ir into ir_q; ir_ready drops the next cycle.
//  DECODE:
//   - Evaluate cond = ir_q[31:28] vs NZCV (EQ..LE, AL = 4'hE).
//   - Capture alu_c <= NZCV[1].
//   - Cond fail: go to DONE; no ALU_OP, S or reg_we activity.
//   - Illegal (ir_q[27:26] != 0, or opcode 8..11 with S bit ir_q[20] = 0): go to DONE with err.
//  RD_RS: entered only if ir_q[25] = 0 and ir_q[4] = 1; rs_rd = 1 for one cycle.
//  Opcode map ir_q[24:21] -> ALU_OP:
//   - 0..7 and 12..15 pass through unchanged.
//   - TST 8 -> 0, TEQ 9 -> 1, CMP 10 -> 2, CMN 11 -> 4.
//   - ALU_OP 8 and A are never issued.
//  EXEC: ALU_OP, imm_sel, shift_ctl and addresses valid; held constant through WB.
//  FLAG: S = 1 for exactly this cycle iff ir_q[20] = 1, otherwise S stays 0. The S rising edge always follows one full stable EXEC cycle.
//  WB: reg_we = 1 unless opcode 8..11; rd_addr valid.
//  DONE: done = 1, err if flagged; outputs return to 0 next cycle; ir_ready = 1.
//  Latency (transfer edge to done): 5 cycles, 6 with RD_RS, 2 on cond fail or illegal.
//  alu_c is not re-sampled after DECODE, so a flag update in FLAG cannot change ADC/SBC/RSC carry mid-op.
//  ir_valid outside IDLE is ignored; no instruction is dropped or queued.
// STRUCTURE
//  cpu_pkg: cond-code localparams (EQ..NV), opcode localparams, state encoding, NZCV bit indices (fN=3, fZ=2, fC=1, fV=0).
//  Sub-module cond_check (combinational): cond[3:0] + NZCV[3:0] -> pass.
//  Top: FSM, ir_q, alu_c register, opcode map.
// TESTING
//  ADD r2,r1,r3 (ir=E0812003), NZCV=0:
//   - ALU_OP=4 in EXEC..WB, S never high.
//   - reg_we with rd_addr=2 at T+4; done at T+5.
//  CMP r1,#5 (E3510005):
//   - ALU_OP=2, imm_sel=1; S pulse at T+3; reg_we never asserts.
//  ADDEQ (00812003) with NZCV=0000:
//   - done at T+2; ALU_OP, S and reg_we stay 0.
//  ADD r2,r1,r3,LSL r4 (E0812413):
//   - rs_rd with rs_addr=4 at T+2; reg_we at T+5; done at T+6.
//  ADCS (E0B12003), NZCV=0010 at DECODE, flag update clears C:
//   - alu_c=1 held through WB.
//  Illegal and reset cases:
//   - E1410005 (CMP, S=0): done+err at T+2, no reg_we.
//   - rst_n=0 during EXEC: next edge all outputs 0, ir_ready=1, no reg_we.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-processing issue controller: condition codes,
// opcodes, NZCV bit positions, FSM state encoding and the opcode-to-ALU map.
package cpu_pkg;

    localparam int unsigned IR_W    = 32;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned SHIFT_W = 12;

    localparam int unsigned F_N = 3;
    localparam int unsigned F_Z = 2;
    localparam int unsigned F_C = 1;
    localparam int unsigned F_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [OP_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_W-1:0] OP_EOR = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h4;
    localparam logic [OP_W-1:0] OP_TST = 4'h8;
    localparam logic [OP_W-1:0] OP_TEQ = 4'h9;
    localparam logic [OP_W-1:0] OP_CMP = 4'hA;
    localparam logic [OP_W-1:0] OP_CMN = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_RD_RS  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FLAG   = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Compare-class opcodes (TST/TEQ/CMP/CMN) only update flags, never write Rd.
    function automatic logic is_test_op(input logic [OP_W-1:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    function automatic logic [OP_W-1:0] map_opcode(input logic [OP_W-1:0] op);
        case (op)
            OP_TST:  return OP_AND;
            OP_TEQ:  return OP_EOR;
            OP_CMP:  return OP_SUB;
            OP_CMN:  return OP_ADD;
            default: return op;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against the current NZCV flags.
module cond_check
    import cpu_pkg::*;
#(
    parameter bit NV_EXECUTES = 1'b0
) (
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] nzcv,
    output logic              pass_c
);

    logic n, z, c, v;

    always_comb begin
        n      = nzcv[F_N];
        z      = nzcv[F_Z];
        c      = nzcv[F_C];
        v      = nzcv[F_V];
        pass_c = 1'b0;
        case (cond)
            COND_EQ: pass_c = z;
            COND_NE: pass_c = !z;
            COND_CS: pass_c = c;
            COND_CC: pass_c = !c;
            COND_MI: pass_c = n;
            COND_PL: pass_c = !n;
            COND_VS: pass_c = v;
            COND_VC: pass_c = !v;
            COND_HI: pass_c = c && !z;
            COND_LS: pass_c = !c || z;
            COND_GE: pass_c = (n == v);
            COND_LT: pass_c = (n != v);
            COND_GT: pass_c = !z && (n == v);
            COND_LE: pass_c = z || (n != v);
            COND_AL: pass_c = 1'b1;
            COND_NV: pass_c = NV_EXECUTES;
            default: pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue/control FSM for data-processing instructions: decode, optional Rs read,
// ALU drive, flag-latch strobe and write-back. Outputs are registered from the current state.
module dp_issue_ctrl
    import cpu_pkg::*;
#(
    parameter bit NV_EXECUTES = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ir_valid,
    input  logic [IR_W-1:0]     ir,
    output logic                ir_ready,
    input  logic [FLAG_W-1:0]   NZCV,
    output logic [OP_W-1:0]     ALU_OP,
    output logic                S,
    output logic                alu_c,
    output logic [ADDR_W-1:0]   rn_addr,
    output logic [ADDR_W-1:0]   rm_addr,
    output logic [ADDR_W-1:0]   rs_addr,
    output logic                rs_rd,
    output logic                imm_sel,
    output logic [SHIFT_W-1:0]  shift_ctl,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                reg_we,
    output logic                done,
    output logic                err
);

    state_e              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic                illegal_q, illegal_d;
    logic                alu_c_q, alu_c_d;
    logic                ir_ready_q, ir_ready_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                s_q, s_d;
    logic [ADDR_W-1:0]   rn_addr_q, rn_addr_d;
    logic [ADDR_W-1:0]   rm_addr_q, rm_addr_d;
    logic [ADDR_W-1:0]   rs_addr_q, rs_addr_d;
    logic                rs_rd_q, rs_rd_d;
    logic                imm_sel_q, imm_sel_d;
    logic [SHIFT_W-1:0]  shift_ctl_q, shift_ctl_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                reg_we_q, reg_we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                cond_pass_c;
    logic [OP_W-1:0]     opcode_c;
    logic                illegal_c;
    logic                ctl_win_c;
    logic                alu_win_c;

    cond_check #(.NV_EXECUTES(NV_EXECUTES)) u_cond_check (
        .cond   (ir_q[31:28]),
        .nzcv   (NZCV),
        .pass_c (cond_pass_c)
    );

    assign opcode_c  = ir_q[24:21];
    assign illegal_c = (ir_q[27:26] != 2'b00) || (is_test_op(opcode_c) && !ir_q[20]);
    assign ctl_win_c = (state_q == ST_RD_RS) || (state_q == ST_EXEC) ||
                       (state_q == ST_FLAG)  || (state_q == ST_WB);
    assign alu_win_c = (state_q == ST_EXEC) || (state_q == ST_FLAG) || (state_q == ST_WB);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        illegal_d   = illegal_q;
        alu_c_d     = alu_c_q;
        alu_op_d    = '0;
        s_d         = 1'b0;
        rn_addr_d   = '0;
        rm_addr_d   = '0;
        rs_addr_d   = '0;
        rs_rd_d     = 1'b0;
        imm_sel_d   = 1'b0;
        shift_ctl_d = '0;
        rd_addr_d   = '0;
        reg_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ir_valid) begin
                    ir_d      = ir;
                    illegal_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Carry is frozen here so a mid-op flag latch cannot disturb ADC/SBC/RSC.
                alu_c_d = NZCV[F_C];
                if (illegal_c) begin
                    illegal_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (!cond_pass_c) begin
                    state_d = ST_DONE;
                end else if (!ir_q[25] && ir_q[4]) begin
                    state_d = ST_RD_RS;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_RD_RS: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_FLAG;
            ST_FLAG:  state_d = ST_WB;
            ST_WB:    state_d = ST_DONE;
            ST_DONE: begin
                alu_c_d = 1'b0;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (ctl_win_c) begin
            rn_addr_d   = ir_q[19:16];
            rm_addr_d   = ir_q[3:0];
            rs_addr_d   = ir_q[11:8];
            imm_sel_d   = ir_q[25];
            shift_ctl_d = ir_q[11:0];
            rd_addr_d   = ir_q[15:12];
        end
        if (alu_win_c) begin
            alu_op_d = map_opcode(opcode_c);
        end
        rs_rd_d    = (state_q == ST_RD_RS);
        s_d        = (state_q == ST_FLAG) && ir_q[20];
        reg_we_d   = (state_q == ST_WB) && !is_test_op(opcode_c);
        done_d     = (state_q == ST_DONE);
        err_d      = (state_q == ST_DONE) && illegal_q;
        ir_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            illegal_q   <= 1'b0;
            alu_c_q     <= 1'b0;
            ir_ready_q  <= 1'b1;
            alu_op_q    <= '0;
            s_q         <= 1'b0;
            rn_addr_q   <= '0;
            rm_addr_q   <= '0;
            rs_addr_q   <= '0;
            rs_rd_q     <= 1'b0;
            imm_sel_q   <= 1'b0;
            shift_ctl_q <= '0;
            rd_addr_q   <= '0;
            reg_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            illegal_q   <= illegal_d;
            alu_c_q     <= alu_c_d;
            ir_ready_q  <= ir_ready_d;
            alu_op_q    <= alu_op_d;
            s_q         <= s_d;
            rn_addr_q   <= rn_addr_d;
            rm_addr_q   <= rm_addr_d;
            rs_addr_q   <= rs_addr_d;
            rs_rd_q     <= rs_rd_d;
            imm_sel_q   <= imm_sel_d;
            shift_ctl_q <= shift_ctl_d;
            rd_addr_q   <= rd_addr_d;
            reg_we_q    <= reg_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ir_ready  = ir_ready_q;
    assign ALU_OP    = alu_op_q;
    assign S         = s_q;
    assign alu_c     = alu_c_q;
    assign rn_addr   = rn_addr_q;
    assign rm_addr   = rm_addr_q;
    assign rs_addr   = rs_addr_q;
    assign rs_rd     = rs_rd_q;
    assign imm_sel   = imm_sel_q;
    assign shift_ctl = shift_ctl_q;
    assign rd_addr   = rd_addr_q;
    assign reg_we    = reg_we_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Self-checking bench for dp_issue_ctrl: directed encodings plus randomized
// back-to-back instructions compared cycle by cycle against a timeline model.
module tb_dp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_valid;
    logic [31:0] ir;
    logic        ir_ready;
    logic [3:0]  NZCV;
    logic [3:0]  ALU_OP;
    logic        S;
    logic        alu_c;
    logic [3:0]  rn_addr, rm_addr, rs_addr, rd_addr;
    logic        rs_rd, imm_sel, reg_we, done, err;
    logic [11:0] shift_ctl;

    int checks = 0;
    int errors = 0;

    dp_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
        .NZCV(NZCV), .ALU_OP(ALU_OP), .S(S), .alu_c(alu_c),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr), .rs_rd(rs_rd),
        .imm_sel(imm_sel), .shift_ctl(shift_ctl), .rd_addr(rd_addr),
        .reg_we(reg_we), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] observed();
        return {ir_ready, ALU_OP, S, alu_c, rn_addr, rm_addr, rs_addr, rs_rd,
                imm_sel, shift_ctl, rd_addr, reg_we, done, err};
    endfunction

    // Conditions come in complementary pairs: odd codes invert the even base test.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic base;
        if (cond == 4'hE) return 1'b1;
        if (cond == 4'hF) return 1'b0;
        case (cond[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = (f[3] == f[0]);
            default: base = ~f[2] & (f[3] == f[0]);
        endcase
        return cond[0] ? ~base : base;
    endfunction

    function automatic bit is_illegal(input logic [31:0] i);
        int op = int'(i[24:21]);
        return (i[27:26] != 2'b00) || (op >= 8 && op <= 11 && !i[20]);
    endfunction

    function automatic bit executes(input logic [31:0] i, input logic [3:0] f);
        return !is_illegal(i) && cond_ok(i[31:28], f);
    endfunction

    function automatic int rs_extra(input logic [31:0] i, input logic [3:0] f);
        return (executes(i, f) && !i[25] && i[4]) ? 1 : 0;
    endfunction

    function automatic int latency(input logic [31:0] i, input logic [3:0] f);
        return executes(i, f) ? 5 + rs_extra(i, f) : 2;
    endfunction

    // Expected outputs k edges after the transfer edge.
    function automatic logic [39:0] expected(input logic [31:0] i, input logic [3:0] f, input int k);
        int lat = latency(i, f);
        int r = rs_extra(i, f);
        int op = int'(i[24:21]);
        logic [3:0] alu_v = i[24:21];
        logic x_rdy, x_s, x_c, x_rsrd, x_imm, x_we, x_done, x_err;
        logic [3:0] x_op, x_rn, x_rm, x_rs, x_rd;
        logic [11:0] x_sh;
        bit ex = executes(i, f);
        bit ctl = ex && k >= 2 && k <= 4 + r;
        if (op == 8) alu_v = 4'd0;
        else if (op == 9) alu_v = 4'd1;
        else if (op == 10) alu_v = 4'd2;
        else if (op == 11) alu_v = 4'd4;
        x_rdy  = (k == lat);
        x_done = (k == lat);
        x_err  = (k == lat) && is_illegal(i);
        x_c    = (k >= 1 && k < lat) ? f[1] : 1'b0;
        x_op   = (ex && k >= 2 + r && k <= 4 + r) ? alu_v : 4'd0;
        x_s    = ex && (k == 3 + r) && i[20];
        x_rsrd = (r == 1) && (k == 2);
        x_we   = ex && (k == 4 + r) && !(op >= 8 && op <= 11);
        x_rn   = ctl ? i[19:16] : 4'd0;
        x_rm   = ctl ? i[3:0] : 4'd0;
        x_rs   = ctl ? i[11:8] : 4'd0;
        x_imm  = ctl ? i[25] : 1'b0;
        x_sh   = ctl ? i[11:0] : 12'd0;
        x_rd   = ctl ? i[15:12] : 4'd0;
        return {x_rdy, x_op, x_s, x_c, x_rn, x_rm, x_rs, x_rsrd, x_imm, x_sh, x_rd, x_we, x_done, x_err};
    endfunction

    // Issue one instruction from IDLE and compare every cycle up to done; garbage ir_valid while busy.
    task automatic exec_and_check(input logic [31:0] instr, input logic [3:0] nz0,
                                  input logic [3:0] nz1, input string name);
        int lat = latency(instr, nz0);
        logic [39:0] obs, exp_v;
        ir_valid = 1'b1;
        ir = instr;
        NZCV = nz0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            obs = observed();
            exp_v = expected(instr, nz0, k);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s ir=%h k=%0d got=%h exp=%h", name, instr, k, obs, exp_v);
            end
            if (k == 1) NZCV = nz1;
            if (k < lat) begin
                ir_valid = 1'($urandom_range(0, 1));
                ir = $urandom;
            end else begin
                ir_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ir_valid = 1'b0;
        ir = '0;
        NZCV = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (observed() !== 40'h80_0000_0000) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", observed(), 40'h80_0000_0000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== 40'h80_0000_0000) begin
            errors++;
            $display("FAIL idle_after_reset got=%h exp=%h", observed(), 40'h80_0000_0000);
        end
    endtask

    task automatic test_directed();
        exec_and_check(32'hE0812003, 4'b0000, 4'b0000, "add_reg");
        exec_and_check(32'hE3510005, 4'b0000, 4'b0110, "cmp_imm");
        exec_and_check(32'h00812003, 4'b0000, 4'b0000, "addeq_fail");
        exec_and_check(32'h00812003, 4'b0100, 4'b0000, "addeq_pass");
        exec_and_check(32'hE0812413, 4'b0000, 4'b0000, "add_lsl_rs");
        exec_and_check(32'hE0B12003, 4'b0010, 4'b0000, "adcs_carry_hold");
        exec_and_check(32'hE1410005, 4'b0000, 4'b0000, "cmp_no_s_illegal");
        exec_and_check(32'hE4812003, 4'b0000, 4'b0000, "bad_class_illegal");
        exec_and_check(32'hF0812003, 4'b1111, 4'b0000, "nv_never");
        exec_and_check(32'h80812003, 4'b0010, 4'b0000, "hi_pass");
        exec_and_check(32'hD0812003, 4'b1000, 4'b0000, "le_pass");
    endtask

    task automatic test_idle_quiet();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (observed() !== 40'h80_0000_0000) begin
                errors++;
                $display("FAIL idle_quiet got=%h exp=%h", observed(), 40'h80_0000_0000);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        ir_valid = 1'b1;
        ir = 32'hE0912003;
        NZCV = 4'b0010;
        @(negedge clk);
        ir_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== 40'h80_0000_0000) begin
            errors++;
            $display("FAIL reset_mid_exec got=%h exp=%h", observed(), 40'h80_0000_0000);
        end
        rst_n = 1'b1;
        test_idle_quiet();
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] instr;
        logic [3:0] nz0, nz1;
        for (int n = 0; n < 300; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 7) != 0) instr[27:26] = 2'b00;
            if ($urandom_range(0, 3) == 0) instr[31:28] = 4'hE;
            nz0 = 4'($urandom);
            nz1 = 4'($urandom);
            exec_and_check(instr, nz0, nz1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_quiet();
        test_reset_mid_exec();
        test_back_to_back_random();
        test_idle_quiet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
